pc_branch_unit: RTL and testbench

- Program-counter stage for the single-cycle RISC-V core.
- Sits directly downstream of the branch-offset left-shift stage. Consumes its already-shifted offset and forms branch and JALR targets.
- Registers the PC, with a stall hold and a misaligned-target trap FSM.
- Output pc feeds instruction memory; pc_plus4 feeds the link-register writeback mux.

---
 rtl/pc_branch_unit.sv | 97 +++++++++
 tb/tb_pc_branch_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// PC register with branch/JALR target formation, stall hold and misaligned-target trap FSM.
// Optional build macro PC_COMPRESSED_EN relaxes the alignment check to 2 bytes (C extension).
module pc_branch_unit #(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [N-1:0] TRAP_VEC = N'(32'h0000_0100)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         branch_taken,
    input  logic         jalr,
    input  logic [N-1:0] offset_shl,
    input  logic [N-1:0] rs1,
    input  logic         trap_ack,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus4,
    output logic         misaligned,
    output logic [N-1:0] bad_addr,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        TRAP = 2'd2
    } state_e;

    state_e       state_q;
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;
    logic         mis_q;
    logic [N-1:0] bad_q;

    logic [N-1:0] br_tgt;
    logic [N-1:0] jr_tgt;
    logic [N-1:0] tgt;
    logic         redirect;
    logic         tgt_mis;

    assign br_tgt   = pc_q + offset_shl;
    assign jr_tgt   = (rs1 + offset_shl) & {{(N-1){1'b1}}, 1'b0};
    assign redirect = jalr | branch_taken;
    assign tgt      = jalr ? jr_tgt : br_tgt;

    // Only redirects are checked; the sequential pc+4 path can never misalign.
`ifdef PC_COMPRESSED_EN
    assign tgt_mis = redirect & tgt[0];
`else
    assign tgt_mis = redirect & (tgt[1:0] != 2'b00);
`endif

    assign pc_plus4 = pc_q + N'(4);
    assign pc_d     = redirect ? tgt : pc_plus4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            mis_q   <= 1'b0;
            bad_q   <= '0;
        end else begin
            case (state_q)
                RUN, HOLD: begin
                    if (!en) begin
                        state_q <= HOLD;
                    end else if (tgt_mis) begin
                        pc_q    <= TRAP_VEC;
                        bad_q   <= tgt;
                        mis_q   <= 1'b1;
                        state_q <= TRAP;
                    end else begin
                        pc_q    <= pc_d;
                        state_q <= RUN;
                    end
                end
                TRAP: begin
                    // pc stays on TRAP_VEC; it only advances after the ack edge.
                    if (trap_ack) begin
                        mis_q   <= 1'b0;
                        state_q <= RUN;
                    end
                end
                default: begin
                    mis_q   <= 1'b0;
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign pc         = pc_q;
    assign misaligned = mis_q;
    assign bad_addr   = bad_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: stimulus pushes expected state, a monitor pops and compares.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        branch_taken;
    logic        jalr;
    logic [31:0] offset_shl;
    logic [31:0] rs1;
    logic        trap_ack;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic [31:0] bad_addr;
    logic [1:0]  state;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  st;
        logic        mis;
        logic [31:0] bad;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    event mon_ev;

    pc_branch_unit dut (
        .clk(clk), .rst(rst), .en(en), .branch_taken(branch_taken), .jalr(jalr),
        .offset_shl(offset_shl), .rs1(rs1), .trap_ack(trap_ack),
        .pc(pc), .pc_plus4(pc_plus4), .misaligned(misaligned),
        .bad_addr(bad_addr), .state(state)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: compares on every falling edge (and on demand for async events).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or mon_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc",         pc,                 e.pc);
                chk("pc_plus4",   pc_plus4,           e.pc + 32'd4);
                chk("state",      {30'b0, state},     {30'b0, e.st});
                chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
                chk("bad_addr",   bad_addr,           e.bad);
            end
        end
    end

    task automatic step(input logic e, input logic b, input logic j,
                        input logic [31:0] off, input logic [31:0] r, input logic ack,
                        input logic [31:0] epc, input logic [1:0] est,
                        input logic emis, input logic [31:0] ebad);
        exp_t x;
        en = e; branch_taken = b; jalr = j; offset_shl = off; rs1 = r; trap_ack = ack;
        x.pc = epc; x.st = est; x.mis = emis; x.bad = ebad;
        q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    initial begin
        exp_t x;
        rst = 1'b0; en = 1'b1; branch_taken = 1'b0; jalr = 1'b0;
        offset_shl = '0; rs1 = '0; trap_ack = 1'b0;
        #1;
        // Reset held with en=1
        step(1, 0, 0, 32'h0,        32'h0,    0, 32'h0,        2'd0, 0, 32'h0);
        step(1, 0, 0, 32'h0,        32'h0,    0, 32'h0,        2'd0, 0, 32'h0);
        rst = 1'b1;
        step(1, 0, 0, 32'h0,        32'h0,    0, 32'h4,        2'd0, 0, 32'h0);
        step(1, 0, 0, 32'h0,        32'h0,    0, 32'h8,        2'd0, 0, 32'h0);
        step(1, 0, 0, 32'h0,        32'h0,    0, 32'hC,        2'd0, 0, 32'h0);
        // Branches: backward, forward, wrap
        step(1, 1, 0, 32'hFFFFFFFC, 32'h0,    0, 32'h8,        2'd0, 0, 32'h0);
        step(1, 1, 0, 32'h10,       32'h0,    0, 32'h18,       2'd0, 0, 32'h0);
        step(1, 1, 0, 32'hFFFFFFEC, 32'h0,    0, 32'h4,        2'd0, 0, 32'h0);
        step(1, 1, 0, 32'hFFFFFFF8, 32'h0,    0, 32'hFFFFFFFC, 2'd0, 0, 32'h0);
        step(1, 0, 0, 32'h0,        32'h0,    0, 32'h0,        2'd0, 0, 32'h0);
        // JALR wins over branch, bit 0 cleared
        step(1, 1, 1, 32'h4,        32'h1001, 0, 32'h1004,     2'd0, 0, 32'h0);
        step(1, 0, 1, 32'h4,        32'h1C,   0, 32'h20,       2'd0, 0, 32'h0);
        // Stall: redirect inputs ignored while en=0
        step(0, 1, 0, 32'h40,       32'h0,    0, 32'h20,       2'd1, 0, 32'h0);
        step(0, 0, 1, 32'h40,       32'h0,    0, 32'h20,       2'd1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        32'h0,    0, 32'h20,       2'd1, 0, 32'h0);
        step(1, 1, 0, 32'h8,        32'h0,    0, 32'h28,       2'd0, 0, 32'h0);
        step(1, 0, 1, 32'h0,        32'h0,    0, 32'h0,        2'd0, 0, 32'h0);
`ifdef PC_COMPRESSED_EN
        step(1, 1, 0, 32'h6,        32'h0,    0, 32'h6,        2'd0, 0, 32'h0);
        step(1, 0, 1, 32'h2,        32'h10,   0, 32'h12,       2'd0, 0, 32'h0);
`else
        // Misaligned branch target -> trap
        step(1, 1, 0, 32'h6,        32'h0,    0, 32'h100,      2'd2, 1, 32'h6);
        step(1, 1, 0, 32'h10,       32'h0,    0, 32'h100,      2'd2, 1, 32'h6);
        step(0, 0, 1, 32'h10,       32'h0,    0, 32'h100,      2'd2, 1, 32'h6);
        step(1, 1, 0, 32'h10,       32'h0,    1, 32'h100,      2'd0, 0, 32'h6);
        step(1, 0, 0, 32'h0,        32'h0,    0, 32'h104,      2'd0, 0, 32'h6);
        step(1, 0, 0, 32'h0,        32'h0,    1, 32'h108,      2'd0, 0, 32'h6);
        // Misaligned JALR taken straight out of HOLD
        step(0, 0, 0, 32'h0,        32'h0,    0, 32'h108,      2'd1, 0, 32'h6);
        step(1, 0, 1, 32'h2,        32'h10,   0, 32'h100,      2'd2, 1, 32'h12);
        step(1, 0, 0, 32'h0,        32'h0,    0, 32'h100,      2'd2, 1, 32'h12);
`endif
        // Asynchronous reset mid-cycle, no clock edge needed
        rst = 1'b0;
        #1;
        x.pc = 32'h0; x.st = 2'd0; x.mis = 1'b0; x.bad = 32'h0;
        q.push_back(x);
        -> mon_ev;
        #1;
        step(1, 0, 0, 32'h0,        32'h0,    0, 32'h0,        2'd0, 0, 32'h0);
        rst = 1'b1;
        step(1, 0, 0, 32'h0,        32'h0,    0, 32'h4,        2'd0, 0, 32'h0);
        step(1, 1, 0, 32'hC,        32'h0,    0, 32'h10,       2'd0, 0, 32'h0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
